// File: rtl/simon_control_stream.sv
// Streaming SIMON block cipher engine: U unrolled rounds per clock, ECB/CBC chaining,
// valid/ready handshakes on input and output, abort when the key array goes invalid.
module simon_control_stream #(
  parameter int N  = 16,
  parameter int T  = 32,
  parameter int U  = 1,
  parameter int CB = ((T / U) > 1) ? $clog2(T / U) : 1
) (
  input  logic                  clk,
  input  logic                  R,
  input  logic [T-1:0][N-1:0]   keys,
  input  logic                  keyValid,
  input  logic                  enc_dec,
  input  logic                  mode,
  input  logic [2*N-1:0]        iv,
  input  logic                  ivLoad,
  input  logic [2*N-1:0]        din,
  input  logic                  inValid,
  output logic                  inReady,
  output logic [2*N-1:0]        dout,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  busy
);

  localparam int CYC = T / U;
  localparam logic [CB-1:0] LAST = CB'(CYC - 1);

  if (T % U != 0) begin : g_bad_unroll
    $error("simon_control_stream: U must divide T");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int r);
    int s;
    s = r % N;
    return (s == 0) ? v : ((v << s) | (v >> (N - s)));
  endfunction

  function automatic logic [2*N-1:0] swap_halves(input logic [2*N-1:0] b);
    return {b[N-1:0], b[2*N-1:N]};
  endfunction

  function automatic logic [2*N-1:0] round_f(input logic [2*N-1:0] b, input logic [N-1:0] k);
    logic [N-1:0] x;
    logic [N-1:0] y;
    x = b[2*N-1:N];
    y = b[N-1:0];
    return {y ^ (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2) ^ k, x};
  endfunction

  state_t            state_reg, state_next;
  logic [CB-1:0]     cnt_reg, cnt_next;
  logic [2*N-1:0]    blk_reg, blk_next;
  logic              enc_reg, enc_next;
  logic              mode_reg, mode_next;
  logic [2*N-1:0]    din_reg, din_next;
  logic [2*N-1:0]    chain_reg, chain_next;
  logic [2*N-1:0]    dout_reg, dout_next;
  logic              out_valid_reg, out_valid_next;
  logic              busy_reg, busy_next;

  // Keys viewed as one group of U keys per round cycle; decrypt walks the groups
  // and the keys inside each group in reverse order.
  logic [CYC-1:0][U-1:0][N-1:0] key_grp;
  logic [CB-1:0]                grp_idx;
  logic [N-1:0]                 rkeys [U];
  logic [2*N-1:0]               stage_out;
  logic [2*N-1:0]               result;
  logic [2*N-1:0]               chain_eff;

  assign key_grp = keys;
  assign grp_idx = enc_reg ? cnt_reg : (LAST - cnt_reg);

  for (genvar gi = 0; gi < U; gi++) begin : g_rkey
    assign rkeys[gi] = enc_reg ? key_grp[grp_idx][gi] : key_grp[grp_idx][U-1-gi];
  end

  always_comb begin
    stage_out = blk_reg;
    for (int i = 0; i < U; i++) begin
      stage_out = round_f(stage_out, rkeys[i]);
    end
  end

  assign result    = enc_reg ? stage_out : swap_halves(stage_out);
  // An IV loaded in the accept cycle already applies to that block.
  assign chain_eff = ((state_reg == IDLE) && ivLoad) ? iv : chain_reg;
  assign inReady   = (state_reg == IDLE) && keyValid && !R;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    blk_next       = blk_reg;
    enc_next       = enc_reg;
    mode_next      = mode_reg;
    din_next       = din_reg;
    chain_next     = chain_reg;
    dout_next      = dout_reg;
    out_valid_next = out_valid_reg;
    case (state_reg)
      IDLE: begin
        if (ivLoad) chain_next = iv;
        if (inValid && inReady) begin
          enc_next   = enc_dec;
          mode_next  = mode;
          din_next   = din;
          blk_next   = enc_dec ? (mode ? (din ^ chain_eff) : din) : swap_halves(din);
          cnt_next   = '0;
          state_next = ROUND;
        end
      end
      ROUND: begin
        if (!keyValid) begin
          out_valid_next = 1'b0;
          cnt_next       = '0;
          state_next     = IDLE;
        end else begin
          blk_next = stage_out;
          cnt_next = cnt_reg + CB'(1);
          if (cnt_reg == LAST) begin
            dout_next      = (!enc_reg && mode_reg) ? (result ^ chain_reg) : result;
            if (mode_reg) chain_next = enc_reg ? result : din_reg;
            out_valid_next = 1'b1;
            cnt_next       = '0;
            state_next     = DONE;
          end
        end
      end
      DONE: begin
        if (!keyValid || outReady) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      blk_reg       <= '0;
      enc_reg       <= 1'b0;
      mode_reg      <= 1'b0;
      din_reg       <= '0;
      chain_reg     <= '0;
      dout_reg      <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      blk_reg       <= blk_next;
      enc_reg       <= enc_next;
      mode_reg      <= mode_next;
      din_reg       <= din_next;
      chain_reg     <= chain_next;
      dout_reg      <= dout_next;
      out_valid_reg <= out_valid_next;
      busy_reg      <= busy_next;
    end
  end

  assign dout     = dout_reg;
  assign outValid = out_valid_reg;
  assign busy     = busy_reg;

endmodule
